// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and constants for the Huffman code generator.
//   state_t      : frame controller states (IDLE, COUNT, MERGE, DONE)
//   *_DEF        : default symbol count, count width and code width
//   IDW / LENW   : group-id and code-length register widths (NSYM <= 8)
//   WEXT         : extra weight bits so summed counts of 8 symbols never wrap
package huffman_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NSYM_DEF = 6;
  localparam int CW_DEF   = 8;
  localparam int LW_DEF   = 8;
  localparam int IDW      = 3;
  localparam int LENW     = 4;
  localparam int WEXT     = 4;

endpackage

// File: rtl/huff_min2.sv
// huff_min2: combinational two-smallest selector over the active groups.
// Ports:
//   i_wt   : NSYM flattened weights, group g at [g*WW +: WW]
//   i_act  : one active flag per group id
//   o_min1 : id of the active group with the smallest weight
//   o_min2 : id of the next smallest active group (excluding o_min1)
// Ties go to the lower group id because the scan is ascending with strict '<'.
module huff_min2
  import huffman_pkg::*;
#(
  parameter int NSYM = NSYM_DEF,
  parameter int WW   = CW_DEF + WEXT
) (
  input  logic [NSYM*WW-1:0] i_wt,
  input  logic [NSYM-1:0]    i_act,
  output logic [IDW-1:0]     o_min1,
  output logic [IDW-1:0]     o_min2
);

  logic          w_f1, w_f2;
  logic [WW-1:0] w_b1, w_b2;

  always_comb begin
    w_f1   = 1'b0;
    w_b1   = '0;
    o_min1 = '0;
    for (int g = 0; g < NSYM; g++) begin
      if (i_act[g] && (!w_f1 || (i_wt[g*WW +: WW] < w_b1))) begin
        w_f1   = 1'b1;
        w_b1   = i_wt[g*WW +: WW];
        o_min1 = IDW'(g);
      end
    end
    w_f2   = 1'b0;
    w_b2   = '0;
    o_min2 = '0;
    for (int g = 0; g < NSYM; g++) begin
      if (i_act[g] && (IDW'(g) != o_min1) &&
          (!w_f2 || (i_wt[g*WW +: WW] < w_b2))) begin
        w_f2   = 1'b1;
        w_b2   = i_wt[g*WW +: WW];
        o_min2 = IDW'(g);
      end
    end
  end

endmodule

// File: rtl/huffman_gen.sv
// huffman_gen: counts symbols of a frame, then builds a Huffman code for them.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   gray_valid/last   : sample strobe / final sample of the frame
//   gray_data         : symbol value, legal 1..NSYM
//   busy              : high while merging; samples are ignored
//   err               : sticky per frame, an out-of-range sample was seen
//   CNT_valid, CNT    : pulse in the first merge cycle, flattened counts
//   code_valid, HC, M : pulse after the last merge, right-aligned codes/masks
// One merge round per cycle: the two lightest groups are combined; members of
// the lightest get a 1 prepended to their code, members of the other a 0.
module huffman_gen
  import huffman_pkg::*;
#(
  parameter int NSYM = NSYM_DEF,
  parameter int CW   = CW_DEF,
  parameter int LW   = LW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gray_valid,
  input  logic                 gray_last,
  input  logic [7:0]           gray_data,
  output logic                 busy,
  output logic                 err,
  output logic                 CNT_valid,
  output logic [NSYM*CW-1:0]   CNT,
  output logic                 code_valid,
  output logic [NSYM*LW-1:0]   HC,
  output logic [NSYM*LW-1:0]   M
);

  localparam int WW = CW + WEXT;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  state_t          r_state;
  logic            r_busy, r_err, r_cnt_valid, r_code_valid;
  logic [CW-1:0]   r_cnt [NSYM];
  logic [LW-1:0]   r_hc  [NSYM];
  logic [LW-1:0]   r_m   [NSYM];
  logic [LENW-1:0] r_len [NSYM];
  logic [IDW-1:0]  r_gid [NSYM];
  logic [WW-1:0]   r_wt  [NSYM];
  logic [NSYM-1:0] r_act;
  logic [IDW-1:0]  r_rnd;

  logic                 w_first, w_oor, w_err_nxt;
  logic [CW-1:0]        w_cnt_nxt [NSYM];
  logic [NSYM*WW-1:0]   w_wt_flat;
  logic [IDW-1:0]       w_min1, w_min2, w_lo, w_hi;
  logic [WW-1:0]        w_wsum;

  // A sample seen in IDLE or DONE opens a new frame and clears prior results.
  assign w_first   = (r_state == IDLE) || (r_state == DONE);
  assign w_oor     = (gray_data == 8'd0) || (gray_data > 8'(NSYM));
  assign w_err_nxt = (w_first ? 1'b0 : r_err) | w_oor;

  always_comb begin
    for (int s = 0; s < NSYM; s++) begin
      w_cnt_nxt[s] = w_first ? '0 : r_cnt[s];
      if (gray_data == 8'(s + 1)) w_cnt_nxt[s] = sat_inc(w_cnt_nxt[s]);
    end
  end

  always_comb begin
    w_wt_flat = '0;
    w_wsum    = '0;
    for (int g = 0; g < NSYM; g++) begin
      w_wt_flat[g*WW +: WW] = r_wt[g];
      if ((IDW'(g) == w_min1) || (IDW'(g) == w_min2)) w_wsum = w_wsum + r_wt[g];
    end
  end

  huff_min2 #(
    .NSYM (NSYM),
    .WW   (WW)
  ) u_min2 (
    .i_wt   (w_wt_flat),
    .i_act  (r_act),
    .o_min1 (w_min1),
    .o_min2 (w_min2)
  );

  // The merged group keeps the lower of the two ids.
  assign w_lo = (w_min1 < w_min2) ? w_min1 : w_min2;
  assign w_hi = (w_min1 < w_min2) ? w_min2 : w_min1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt_valid  <= 1'b0;
      r_code_valid <= 1'b0;
      r_act        <= '0;
      r_rnd        <= '0;
      for (int s = 0; s < NSYM; s++) begin
        r_cnt[s] <= '0;
        r_hc[s]  <= '0;
        r_m[s]   <= '0;
        r_len[s] <= '0;
        r_gid[s] <= '0;
        r_wt[s]  <= '0;
      end
    end else begin
      r_cnt_valid  <= 1'b0;
      r_code_valid <= 1'b0;
      case (r_state)
        IDLE, COUNT, DONE: begin
          if (gray_valid) begin
            r_err <= w_err_nxt;
            for (int s = 0; s < NSYM; s++) begin
              r_cnt[s] <= w_cnt_nxt[s];
              if (w_first) begin
                r_hc[s]  <= '0;
                r_m[s]   <= '0;
                r_len[s] <= '0;
              end
            end
            if (gray_last) begin
              // Seed one leaf group per symbol from the final counts.
              r_state     <= MERGE;
              r_busy      <= 1'b1;
              r_cnt_valid <= 1'b1;
              r_rnd       <= '0;
              r_act       <= '1;
              for (int s = 0; s < NSYM; s++) begin
                r_gid[s] <= IDW'(s);
                r_wt[s]  <= WW'(w_cnt_nxt[s]);
              end
            end else begin
              r_state <= COUNT;
            end
          end
        end
        MERGE: begin
          for (int s = 0; s < NSYM; s++) begin
            if (r_gid[s] == w_min1) begin
              r_hc[s]  <= r_hc[s] | (LW'(1) << r_len[s]);
              r_len[s] <= r_len[s] + 1'b1;
              r_m[s]   <= (r_m[s] << 1) | LW'(1);
            end else if (r_gid[s] == w_min2) begin
              r_len[s] <= r_len[s] + 1'b1;
              r_m[s]   <= (r_m[s] << 1) | LW'(1);
            end
            if (r_gid[s] == w_hi) r_gid[s] <= w_lo;
          end
          for (int g = 0; g < NSYM; g++) begin
            if (IDW'(g) == w_lo) r_wt[g] <= w_wsum;
            if (IDW'(g) == w_hi) r_act[g] <= 1'b0;
          end
          if (r_rnd == IDW'(NSYM - 2)) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_code_valid <= 1'b1;
          end else begin
            r_rnd <= r_rnd + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign err        = r_err;
  assign CNT_valid  = r_cnt_valid;
  assign code_valid = r_code_valid;

  always_comb begin
    CNT = '0;
    HC  = '0;
    M   = '0;
    for (int s = 0; s < NSYM; s++) begin
      CNT[s*CW +: CW] = r_cnt[s];
      HC[s*LW +: LW]  = r_hc[s];
      M[s*LW +: LW]   = r_m[s];
    end
  end

endmodule
